// File: rtl/aer_pkg.sv
// Shared definitions for the AER spike arbiter: default sizes, timestamp width
// and the handshake FSM states.
package aer_pkg;

    localparam int AER_N_NEURONS = 8;
    localparam int AER_ADDR_W    = 3;
    localparam int TS_W          = 16;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } aer_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: returns the first set request found when
// searching upward from pointer+1, wrapping at N-1 back to 0.
module rr_priority_picker
    import aer_pkg::*;
#(
    parameter int N      = AER_N_NEURONS,
    parameter int ADDR_W = AER_ADDR_W
) (
    input  logic [N-1:0]      request,
    input  logic [ADDR_W-1:0] pointer,
    output logic              grant_valid,
    output logic [ADDR_W-1:0] grant_index
);

    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_index = '0;
        idx         = 0;
        // Walk from the farthest candidate to the nearest so the nearest set
        // request is the last one written and therefore wins.
        for (int k = N; k >= 1; k--) begin
            idx = int'(pointer) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (request[idx]) begin
                grant_valid = 1'b1;
                grant_index = idx[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/aer_spike_arbiter.sv
// Address-event arbiter: latches per-neuron spikes and serialises them onto a
// valid/ready event bus. Define AER_TIMESTAMP_EN to add the evt_ts output.
module aer_spike_arbiter
    import aer_pkg::*;
#(
    parameter int N_NEURONS = AER_N_NEURONS,
    parameter int ADDR_W    = AER_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_NEURONS-1:0] spike_in,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [ADDR_W-1:0]    evt_addr,
    output logic                 overflow,
`ifdef AER_TIMESTAMP_EN
    output logic [TS_W-1:0]      evt_ts,
`endif
    input  logic                 overflow_clr
);

    aer_state_t             state_reg;
    logic [N_NEURONS-1:0]   pending_reg;
    logic [N_NEURONS-1:0]   pending_next;
    logic [N_NEURONS-1:0]   grant_mask;
    logic [N_NEURONS-1:0]   drop;
    logic [ADDR_W-1:0]      addr_reg;
    logic [ADDR_W-1:0]      ptr_reg;
    logic                   valid_reg;
    logic                   overflow_reg;
    logic                   overflow_next;
    logic                   grant_valid;
    logic [ADDR_W-1:0]      grant_index;
    logic                   load;

    rr_priority_picker #(
        .N      (N_NEURONS),
        .ADDR_W (ADDR_W)
    ) u_picker (
        .request     (pending_reg),
        .pointer     (ptr_reg),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    // A new event is loaded from IDLE, or in HOLD on the accepting edge.
    assign load = grant_valid && ((state_reg == IDLE) || evt_ready);

    generate
        for (genvar gi = 0; gi < N_NEURONS; gi++) begin : g_bit
            assign grant_mask[gi]   = load && (grant_index == ADDR_W'(gi));
            // A fresh spike re-arms the bit even while it is being granted.
            assign pending_next[gi] = (pending_reg[gi] && !grant_mask[gi])
                                    || (enable && spike_in[gi]);
            assign drop[gi]         = enable && spike_in[gi] && pending_reg[gi]
                                    && !grant_mask[gi];
        end
    endgenerate

    // Set takes priority over clear.
    assign overflow_next = (|drop) || (overflow_reg && !overflow_clr);

`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] cnt_reg;
    logic [TS_W-1:0] ts_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg <= '0;
            ts_reg  <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (load) begin
                ts_reg <= cnt_reg;
            end
        end
    end

    assign evt_ts = ts_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            pending_reg  <= '0;
            addr_reg     <= '0;
            ptr_reg      <= ADDR_W'(N_NEURONS - 1);
            valid_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            pending_reg  <= pending_next;
            overflow_reg <= overflow_next;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        addr_reg  <= grant_index;
                        ptr_reg   <= grant_index;
                        valid_reg <= 1'b1;
                        state_reg <= HOLD;
                    end
                end
                HOLD: begin
                    if (evt_ready) begin
                        if (load) begin
                            addr_reg <= grant_index;
                            ptr_reg  <= grant_index;
                        end else begin
                            valid_reg <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: begin
                    valid_reg <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign evt_valid = valid_reg;
    assign evt_addr  = addr_reg;
    assign overflow  = overflow_reg;

endmodule

// File: tb/tb_aer_spike_arbiter.sv
// Directed bench for aer_spike_arbiter; the timestamp step runs only when
// AER_TIMESTAMP_EN is defined.
module tb_aer_spike_arbiter;
    import aer_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] spike_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [2:0] evt_addr;
    logic       overflow;
    logic       overflow_clr;
`ifdef AER_TIMESTAMP_EN
    logic [TS_W-1:0] evt_ts;
    logic [TS_W-1:0] cnt_model;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    aer_spike_arbiter #(
        .N_NEURONS (8),
        .ADDR_W    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .spike_in     (spike_in),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_addr     (evt_addr),
        .overflow     (overflow),
`ifdef AER_TIMESTAMP_EN
        .evt_ts       (evt_ts),
`endif
        .overflow_clr (overflow_clr)
    );

`ifdef AER_TIMESTAMP_EN
    always @(posedge clk) begin
        if (reset) cnt_model <= '0;
        else       cnt_model <= cnt_model + 1'b1;
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b1;
        spike_in     = 8'h00;
        evt_ready    = 1'b0;
        overflow_clr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_addr",  32'(evt_addr),  32'd0);
        check("rst_ovf",   32'(overflow),  32'd0);

        // Single spike on neuron 2: valid only in cycle 2
        spike_in  = 8'b0000_0100;
        evt_ready = 1'b1;
        tick();
        spike_in = 8'h00;
        check("p1_c1_valid", 32'(evt_valid), 32'd0);
        tick();
        check("p1_c2_valid", 32'(evt_valid), 32'd1);
        check("p1_c2_addr",  32'(evt_addr),  32'd2);
        tick();
        check("p1_c3_valid", 32'(evt_valid), 32'd0);
        check("p1_c3_addr",  32'(evt_addr),  32'd2);
        check("p1_ovf",      32'(overflow),  32'd0);

        // All neurons at once: 0..7 back to back
        do_reset();
        spike_in  = 8'hFF;
        evt_ready = 1'b1;
        tick();
        spike_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("ff_valid", 32'(evt_valid), 32'd1);
            check("ff_addr",  32'(evt_addr),  32'(i));
        end
        tick();
        check("ff_done", 32'(evt_valid), 32'd0);

        // 0x81 with back-pressure: addr 0 held, then 7
        do_reset();
        spike_in = 8'h81;
        tick();
        spike_in = 8'h00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 32'(evt_valid), 32'd1);
            check("bp_addr",  32'(evt_addr),  32'd0);
        end
        evt_ready = 1'b1;
        tick();
        check("bp_next_valid", 32'(evt_valid), 32'd1);
        check("bp_next_addr",  32'(evt_addr),  32'd7);
        tick();
        check("bp_end_valid", 32'(evt_valid), 32'd0);

        // Overflow on neuron 3, set-over-clear, then clear
        do_reset();
        spike_in = 8'h08;
        tick();
        check("of_c1_ovf", 32'(overflow), 32'd0);
        tick();
        check("of_c2_ovf",   32'(overflow),  32'd0);
        check("of_c2_valid", 32'(evt_valid), 32'd1);
        check("of_c2_addr",  32'(evt_addr),  32'd3);
        tick();
        spike_in = 8'h00;
        check("of_c3_ovf",  32'(overflow), 32'd1);
        check("of_c3_addr", 32'(evt_addr), 32'd3);
        spike_in     = 8'h08;
        overflow_clr = 1'b1;
        tick();
        check("of_set_wins", 32'(overflow), 32'd1);
        spike_in = 8'h00;
        tick();
        overflow_clr = 1'b0;
        check("of_cleared", 32'(overflow),  32'd0);
        check("of_held",    32'(evt_valid), 32'd1);
        check("of_hold_a",  32'(evt_addr),  32'd3);

        // Disabled capture, then reset during HOLD
        do_reset();
        enable   = 1'b0;
        spike_in = 8'hFF;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("dis_valid", 32'(evt_valid), 32'd0);
        end
        spike_in = 8'h00;
        tick();
        check("dis_after", 32'(evt_valid), 32'd0);
        enable    = 1'b1;
        evt_ready = 1'b0;
        spike_in  = 8'h21;
        tick();
        spike_in = 8'h00;
        tick();
        check("rh_valid", 32'(evt_valid), 32'd1);
        check("rh_addr",  32'(evt_addr),  32'd0);
        reset = 1'b1;
        tick();
        check("rh_rst_valid", 32'(evt_valid), 32'd0);
        check("rh_rst_addr",  32'(evt_addr),  32'd0);
        reset     = 1'b0;
        evt_ready = 1'b1;
        tick();
        tick();
        check("rh_flushed", 32'(evt_valid), 32'd0);

`ifdef AER_TIMESTAMP_EN
        // Timestamps across the counter wrap
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 70000 && cnt_model != 16'hFFFE; i++) begin
            tick();
        end
        check("ts_reach", 32'(cnt_model), 32'h0000_FFFE);
        spike_in = 8'h03;
        tick();
        spike_in = 8'h00;
        tick();
        check("ts_a_addr", 32'(evt_addr), 32'd0);
        check("ts_a",      32'(evt_ts),   32'h0000_FFFF);
        tick();
        check("ts_b_addr", 32'(evt_addr), 32'd1);
        check("ts_b",      32'(evt_ts),   32'h0000_0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aer_spike_arbiter.md
AER_SPIKE_ARBITER -- requirements
Module: aer_spike_arbiter

Interface
REQ-001 SHALL have parameter N_NEURONS, default 8; number of spike inputs arbitrated.
REQ-002 SHALL have parameter ADDR_W, default 3; event address width, equal to clog2(N_NEURONS).
REQ-003 SHALL have port clk, input, 1 bit; single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit; 1 = capture new spikes, 0 = ignore spike_in while still draining pending events.
REQ-006 SHALL have port spike_in, input, N_NEURONS bits; per-neuron spike outputs of the LIF/recursive neurons, one event per high cycle.
REQ-007 SHALL have port evt_valid, output, 1 bit; an event is presented on evt_addr.
REQ-008 SHALL have port evt_ready, input, 1 bit; the consumer accepts the event when evt_valid and evt_ready are both 1.
REQ-009 SHALL have port evt_addr, output, ADDR_W bits; index of the spiking neuron.
REQ-010 SHALL have port overflow, output, 1 bit; sticky flag, a spike was dropped.
REQ-011 SHALL have port overflow_clr, input, 1 bit; clears overflow.

Function
REQ-012 SHALL hold an N_NEURONS-bit pending register; pending[i] is set at the clock edge following any cycle with spike_in[i]=1 and enable=1.
REQ-013 SHALL implement a 2-state FSM: IDLE (evt_valid=0) and HOLD (evt_valid=1).
REQ-014 In IDLE with any pending bit set, SHALL load evt_addr with the selected index, clear that pending bit and enter HOLD on the next edge.
REQ-015 In HOLD, evt_addr and evt_valid SHALL stay stable until accepted.
REQ-016 On acceptance with pending nonzero, SHALL load the next event in the same edge and remain in HOLD (back-to-back, one event per cycle); with pending zero, SHALL return to IDLE.
REQ-017 Selection SHALL be round-robin: search starts at last granted index + 1, wraps from N_NEURONS-1 to 0; the pointer resets to N_NEURONS-1 so that index 0 wins first.
REQ-018 Selection SHALL use the registered pending value only, with no combinational bypass from spike_in; minimum spike-to-evt_valid latency is 2 cycles.
REQ-019 If spike_in[i]=1 in the same cycle that pending[i] is granted, pending[i] SHALL remain 1, because a new event is captured.
REQ-020 If spike_in[i]=1, enable=1, pending[i]=1 and bit i is not granted that cycle, the spike SHALL be dropped and overflow set on the next edge.
REQ-021 overflow_clr SHALL clear overflow; a simultaneous set SHALL win over the clear.
REQ-022 evt_addr SHALL change only when a new event is loaded.

Reset
REQ-023 On reset: pending=0, state=IDLE, evt_valid=0, evt_addr=0, overflow=0, round-robin pointer=N_NEURONS-1.
REQ-024 Reset mid-HOLD SHALL discard the presented event and all pending events without an acceptance.

Configuration
REQ-025 With macro AER_TIMESTAMP_EN defined, SHALL add output evt_ts of TS_W bits (TS_W=16) from a free-running counter that resets to 0 and wraps modulo 2^16.
REQ-026 With AER_TIMESTAMP_EN, evt_ts SHALL capture the counter value on the edge that loads evt_addr and stay stable with it.
REQ-027 Without AER_TIMESTAMP_EN, SHALL have no counter and no evt_ts port; behaviour is otherwise identical.

Structure
REQ-028 The shared package aer_pkg SHALL hold the N_NEURONS and ADDR_W defaults, TS_W, and the FSM state enum (IDLE, HOLD).
REQ-029 The round-robin search SHALL live in a combinational sub-module rr_priority_picker, with inputs request vector and pointer and outputs grant_valid and grant_index.

Verification
REQ-030 Reset, then a single pulse spike_in=8'b0000_0100 in cycle 0 with evt_ready=1 -> evt_valid=1, evt_addr=2 in cycle 2 only; overflow=0.
REQ-031 One-cycle spike_in=8'hFF, evt_ready=1 -> evt_addr 0,1,...,7 on 8 consecutive cycles, then evt_valid=0.
REQ-032 One-cycle spike_in=8'h81 with evt_ready held 0 for 5 cycles -> evt_addr=0 stays stable in HOLD; after evt_ready=1, evt_addr=7 is presented on the next cycle.
REQ-033 spike_in[3] high for 3 consecutive cycles with evt_ready=0 -> overflow=1, one event for addr 3 held; overflow_clr pulse -> overflow=0.
REQ-034 enable=0 with spike_in=8'hFF -> pending stays 0, evt_valid=0; reset asserted while in HOLD -> evt_valid=0 on the next edge.
REQ-035 With AER_TIMESTAMP_EN, a spike accepted across the counter wrap -> evt_ts of 0xFFFF, then 0x0000, on consecutive events as loaded.
